// File: rtl/pixel_out_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_out_pkg
//  Description : Shared constants and helpers for the pixel output stage.
//                - Source-select mode encodings.
//                - Colour-bar lookup returning one on/off bit per channel.
//  Revision    : 1.0  initial release
// ============================================================================
package pixel_out_pkg;

    localparam logic [1:0] MODE_FIFO  = 2'd0;
    localparam logic [1:0] MODE_SOLID = 2'd1;
    localparam logic [1:0] MODE_BARS  = 2'd2;
    localparam logic [1:0] MODE_CHECK = 2'd3;

    localparam int NUM_BARS = 8;

    // Returns {r,g,b} on/off bits for bar index 0..7.
    // The caller widens each bit to a full channel (all ones or zero).
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b111; // white
            3'd1:    rgb = 3'b110; // yellow
            3'd2:    rgb = 3'b011; // cyan
            3'd3:    rgb = 3'b010; // green
            3'd4:    rgb = 3'b101; // magenta
            3'd5:    rgb = 3'b100; // red
            3'd6:    rgb = 3'b001; // blue
            default: rgb = 3'b000; // black
        endcase
        return rgb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_out_stage_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_gen
//  Description : Combinational test-pattern source (colour bars / checker).
//  Ports       : pixel_x_i  - current column
//                pixel_y_i  - current row
//                eff_mode_i - effective source mode
//                color_o    - {r,g,b} pattern colour, zero for other modes
//  Revision    : 1.0  initial release
// ============================================================================
module pattern_gen
    import pixel_out_pkg::*;
#(
    parameter int COLOR_W     = 8,
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int H_ACTIVE    = 640,
    parameter int CHECK_SHIFT = 5
) (
    input  logic [X_W-1:0]       pixel_x_i,
    input  logic [Y_W-1:0]       pixel_y_i,
    input  logic [1:0]           eff_mode_i,
    output logic [3*COLOR_W-1:0] color_o
);

    localparam logic [31:0] BAR_W = 32'(H_ACTIVE / NUM_BARS);

    logic [31:0] w_x_ext;
    logic [31:0] w_thr;
    logic [2:0]  w_bar_idx;
    logic [2:0]  w_bar_bits;
    logic        w_check;
    logic        w_unused;

    assign w_x_ext = 32'(pixel_x_i);

    // Bar index is the last threshold k*BAR_W that pixel_x has reached;
    // columns past the eighth bar stay clamped at index 7.
    always_comb begin
        w_bar_idx = 3'd0;
        w_thr     = 32'd0;
        for (int k = 1; k < NUM_BARS; k++) begin
            w_thr = w_thr + BAR_W;
            if (w_x_ext >= w_thr) begin
                w_bar_idx = 3'(k);
            end
        end
    end

    assign w_bar_bits = bar_rgb(w_bar_idx);
    assign w_check    = pixel_x_i[CHECK_SHIFT] ^ pixel_y_i[CHECK_SHIFT];

    // Only one bit of the row feeds the checker.
    assign w_unused   = ^pixel_y_i;

    always_comb begin
        color_o = '0;
        case (eff_mode_i)
            MODE_BARS:  color_o = {{COLOR_W{w_bar_bits[2]}},
                                   {COLOR_W{w_bar_bits[1]}},
                                   {COLOR_W{w_bar_bits[0]}}};
            MODE_CHECK: color_o = {(3*COLOR_W){w_check}};
            default:    color_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pixel_out_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_out_stage
//  Description : Registered pixel output stage. Selects FIFO pass-through,
//                solid colour, colour bars or checkerboard per active pixel,
//                pops the FWFT line FIFO, blanks outside the active area and
//                tracks FIFO underflow. Mode changes take effect at frame start.
//  Ports       : clk, rst (sync, active-low)
//                pixel_x/pixel_y/video_on - timing generator inputs
//                mode, bg_color           - source select / solid colour
//                fifo_data/fifo_empty/fifo_rd_en - FWFT FIFO handshake
//                clr_underflow            - clears flag and counter
//                pixel_r/g/b, pixel_valid, frame_start - registered outputs
//                underflow, underflow_count - sticky flag / saturating count
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_out_stage
    import pixel_out_pkg::*;
#(
    parameter int COLOR_W     = 8,
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int H_ACTIVE    = 640,
    parameter int CHECK_SHIFT = 5,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [X_W-1:0]       pixel_x,
    input  logic [Y_W-1:0]       pixel_y,
    input  logic                 video_on,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] bg_color,
    input  logic [3*COLOR_W-1:0] fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic                 clr_underflow,
    output logic [COLOR_W-1:0]   pixel_r,
    output logic [COLOR_W-1:0]   pixel_g,
    output logic [COLOR_W-1:0]   pixel_b,
    output logic                 pixel_valid,
    output logic                 frame_start,
    output logic                 underflow,
    output logic [CNT_W-1:0]     underflow_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 w_fs_cond;
    logic [1:0]           w_eff_mode;
    logic                 w_uf_evt;
    logic [3*COLOR_W-1:0] w_pattern;

    logic [1:0]           active_mode_q;
    logic [3*COLOR_W-1:0] color_d, color_q;
    logic                 valid_q;
    logic                 frame_start_q;
    logic                 underflow_d, underflow_q;
    logic [CNT_W-1:0]     count_d, count_q;

    assign w_fs_cond  = video_on && (pixel_x == '0) && (pixel_y == '0);

    // The requested mode is used directly on the frame-start pixel so the
    // new source covers the whole frame, including its first pixel.
    assign w_eff_mode = w_fs_cond ? mode : active_mode_q;

    assign fifo_rd_en = rst && video_on && (w_eff_mode == MODE_FIFO) && !fifo_empty;
    assign w_uf_evt   = video_on && (w_eff_mode == MODE_FIFO) && fifo_empty;

    pattern_gen #(
        .COLOR_W     (COLOR_W),
        .X_W         (X_W),
        .Y_W         (Y_W),
        .H_ACTIVE    (H_ACTIVE),
        .CHECK_SHIFT (CHECK_SHIFT)
    ) u_pattern_gen (
        .pixel_x_i  (pixel_x),
        .pixel_y_i  (pixel_y),
        .eff_mode_i (w_eff_mode),
        .color_o    (w_pattern)
    );

    always_comb begin
        color_d = '0;
        if (video_on) begin
            case (w_eff_mode)
                MODE_FIFO:  color_d = fifo_empty ? bg_color : fifo_data;
                MODE_SOLID: color_d = bg_color;
                default:    color_d = w_pattern;
            endcase
        end
    end

    // Clear is applied before a coincident event, so clear+event yields 1.
    always_comb begin
        underflow_d = underflow_q;
        count_d     = count_q;
        if (clr_underflow) begin
            underflow_d = 1'b0;
            count_d     = '0;
        end
        if (w_uf_evt) begin
            underflow_d = 1'b1;
            if (count_d != CNT_MAX) begin
                count_d = count_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            active_mode_q <= MODE_FIFO;
            color_q       <= '0;
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            count_q       <= '0;
        end else begin
            if (w_fs_cond) begin
                active_mode_q <= mode;
            end
            color_q       <= color_d;
            valid_q       <= video_on;
            frame_start_q <= w_fs_cond;
            underflow_q   <= underflow_d;
            count_q       <= count_d;
        end
    end

    assign pixel_r         = color_q[3*COLOR_W-1:2*COLOR_W];
    assign pixel_g         = color_q[2*COLOR_W-1:COLOR_W];
    assign pixel_b         = color_q[COLOR_W-1:0];
    assign pixel_valid     = valid_q;
    assign frame_start     = frame_start_q;
    assign underflow       = underflow_q;
    assign underflow_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_out_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_out_stage
//  Description : Self-checking bench for pixel_out_stage. Directed vector
//                table followed by randomized cycles against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pixel_out_stage;

    localparam int CW = 8;
    localparam int XW = 10;
    localparam int YW = 10;
    localparam int HA = 640;
    localparam int CS = 5;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic          video_on;
    logic [1:0]    mode;
    logic [23:0]   bg_color;
    logic [23:0]   fifo_data;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          clr_underflow;
    logic [CW-1:0] pixel_r, pixel_g, pixel_b;
    logic          pixel_valid;
    logic          frame_start;
    logic          underflow;
    logic [NW-1:0] underflow_count;

    always #5 clk = ~clk;

    pixel_out_stage #(
        .COLOR_W(CW), .X_W(XW), .Y_W(YW), .H_ACTIVE(HA), .CHECK_SHIFT(CS), .CNT_W(NW)
    ) dut (
        .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .mode(mode), .bg_color(bg_color),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .clr_underflow(clr_underflow), .pixel_r(pixel_r), .pixel_g(pixel_g),
        .pixel_b(pixel_b), .pixel_valid(pixel_valid), .frame_start(frame_start),
        .underflow(underflow), .underflow_count(underflow_count)
    );

    typedef struct {
        logic        rst, von;
        logic [9:0]  x, y;
        logic [1:0]  mode;
        logic [23:0] bg, data;
        logic        empty, clr;
        logic        e_rd;
        logic [23:0] e_rgb;
        logic        e_valid, e_fs, e_uf;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    logic [1:0] m_mode = 2'd0;
    logic       m_uf   = 1'b0;
    int         m_cnt  = 0;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic von, input int x, input int y,
                       input logic [1:0] md, input logic [23:0] bg, input logic [23:0] dat,
                       input logic emp, input logic clr, input logic erd,
                       input logic [23:0] ergb, input logic ev, input logic efs,
                       input logic euf, input int ecnt);
        vec_t v;
        v.rst = r; v.von = von; v.x = 10'(x); v.y = 10'(y); v.mode = md;
        v.bg = bg; v.data = dat; v.empty = emp; v.clr = clr;
        v.e_rd = erd; v.e_rgb = ergb; v.e_valid = ev; v.e_fs = efs;
        v.e_uf = euf; v.e_cnt = 4'(ecnt);
        tbl.push_back(v);
    endtask

    // Behavioural model: derives next outputs from the rules, updates state.
    task automatic model(input vec_t v, output vec_t o);
        logic       fs;
        logic [1:0] eff;
        int         bar;
        o  = v;
        fs  = v.von && (v.x == 0) && (v.y == 0);
        eff = fs ? v.mode : m_mode;
        o.e_rd = v.rst && v.von && (eff == 2'd0) && !v.empty;
        if (!v.rst) begin
            m_mode = 2'd0; m_uf = 1'b0; m_cnt = 0;
            o.e_rgb = 24'h0; o.e_valid = 1'b0; o.e_fs = 1'b0;
        end else begin
            o.e_rgb = 24'h0;
            if (v.von) begin
                case (eff)
                    2'd0: o.e_rgb = v.empty ? v.bg : v.data;
                    2'd1: o.e_rgb = v.bg;
                    2'd2: begin
                        bar = int'(v.x) / (HA / 8);
                        if (bar > 7) bar = 7;
                        o.e_rgb = bars[bar];
                    end
                    default: o.e_rgb = ((((int'(v.x) >> CS) ^ (int'(v.y) >> CS)) & 1) != 0)
                                       ? 24'hFFFFFF : 24'h000000;
                endcase
            end
            o.e_valid = v.von;
            o.e_fs    = fs;
            if (fs) m_mode = v.mode;
            if (v.clr) begin m_uf = 1'b0; m_cnt = 0; end
            if (v.von && eff == 2'd0 && v.empty) begin
                m_uf = 1'b1;
                if (m_cnt < (1 << NW) - 1) m_cnt++;
            end
        end
        o.e_uf  = m_uf;
        o.e_cnt = 4'(m_cnt);
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; video_on = v.von; pixel_x = v.x; pixel_y = v.y;
        mode = v.mode; bg_color = v.bg; fifo_data = v.data;
        fifo_empty = v.empty; clr_underflow = v.clr;
        #1;
        check("fifo_rd_en", 32'(fifo_rd_en), 32'(v.e_rd));
        @(posedge clk);
        #1;
        check("rgb", 32'({pixel_r, pixel_g, pixel_b}), 32'(v.e_rgb));
        check("pixel_valid", 32'(pixel_valid), 32'(v.e_valid));
        check("frame_start", 32'(frame_start), 32'(v.e_fs));
        check("underflow", 32'(underflow), 32'(v.e_uf));
        check("underflow_count", 32'(underflow_count), 32'(v.e_cnt));
    endtask

    initial begin
        vec_t v, o;

        // Reset held with active video and a non-empty FIFO.
        for (int i = 0; i < 3; i++)
            add(0, 1, 0, 0, 0, 24'h0, 24'hAABBCC, 0, 0, 0, 24'h0, 0, 0, 0, 0);
        // Release: FIFO pass-through with one clock lag.
        add(1, 1, 0, 0, 0, 24'h0, 24'h112233, 0, 0, 1, 24'h112233, 1, 1, 0, 0);
        add(1, 1, 1, 0, 0, 24'h0, 24'h445566, 0, 0, 1, 24'h445566, 1, 0, 0, 0);
        add(1, 1, 2, 0, 0, 24'h0, 24'h778899, 0, 0, 1, 24'h778899, 1, 0, 0, 0);
        add(1, 1, 3, 0, 0, 24'h0, 24'hAABBCC, 0, 0, 1, 24'hAABBCC, 1, 0, 0, 0);
        // Blanking: no pop, black output.
        add(1, 0, 640, 0, 0, 24'h0, 24'hDDEEFF, 0, 0, 0, 24'h0, 0, 0, 0, 0);
        // Five empty active cycles -> blue, count 1..5.
        for (int i = 1; i <= 5; i++)
            add(1, 1, 9 + i, 0, 0, 24'h0000FF, 24'h123456, 1, 0, 0, 24'h0000FF, 1, 0, 1, i);
        // Clear alone.
        add(1, 0, 700, 0, 0, 24'h0000FF, 24'h0, 0, 1, 0, 24'h0, 0, 0, 0, 0);
        // Clear coincident with an event -> count 1.
        add(1, 1, 20, 0, 0, 24'h0000FF, 24'h0, 1, 1, 0, 24'h0000FF, 1, 0, 1, 1);
        // Fill to saturation, then one more event holds the count.
        for (int i = 2; i <= 15; i++)
            add(1, 1, 20 + i, 0, 0, 24'h0000FF, 24'h0, 1, 0, 0, 24'h0000FF, 1, 0, 1, i);
        add(1, 1, 40, 0, 0, 24'h0000FF, 24'h0, 1, 0, 0, 24'h0000FF, 1, 0, 1, 15);
        add(1, 0, 700, 0, 0, 24'h0, 24'h0, 0, 1, 0, 24'h0, 0, 0, 0, 0);
        // Mid-frame mode request is ignored.
        add(1, 1, 30, 5, 2, 24'h0, 24'h123456, 0, 0, 1, 24'h123456, 1, 0, 0, 0);
        // Frame start latches bars.
        add(1, 1, 0, 0, 2, 24'h0, 24'h123456, 0, 0, 0, 24'hFFFFFF, 1, 1, 0, 0);
        add(1, 1, 79, 0, 0, 24'h0, 24'h123456, 0, 0, 0, 24'hFFFFFF, 1, 0, 0, 0);
        add(1, 1, 80, 0, 0, 24'h0, 24'h123456, 0, 0, 0, 24'hFFFF00, 1, 0, 0, 0);
        add(1, 1, 639, 0, 0, 24'h0, 24'h123456, 1, 0, 0, 24'h000000, 1, 0, 0, 0);
        // Checker.
        add(1, 1, 0, 0, 3, 24'h0, 24'h123456, 0, 0, 0, 24'h000000, 1, 1, 0, 0);
        add(1, 1, 31, 0, 3, 24'h0, 24'h123456, 0, 0, 0, 24'h000000, 1, 0, 0, 0);
        add(1, 1, 32, 0, 3, 24'h0, 24'h123456, 0, 0, 0, 24'hFFFFFF, 1, 0, 0, 0);
        add(1, 1, 32, 32, 3, 24'h0, 24'h123456, 1, 0, 0, 24'h000000, 1, 0, 0, 0);
        // Mid-frame reset returns to FIFO mode.
        add(0, 1, 5, 0, 2, 24'h0, 24'h010203, 0, 0, 0, 24'h0, 0, 0, 0, 0);
        add(1, 0, 5, 0, 2, 24'h0, 24'h010203, 0, 0, 0, 24'h0, 0, 0, 0, 0);
        add(1, 1, 6, 0, 2, 24'h0, 24'h010203, 0, 0, 1, 24'h010203, 1, 0, 0, 0);

        foreach (tbl[i]) apply(tbl[i]);

        // Randomized phase, starting from reset.
        for (int i = 0; i < 600; i++) begin
            v.rst   = (i < 2) ? 1'b0 : ($urandom_range(0, 39) != 0);
            v.von   = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 9) == 0) begin
                v.x = 10'd0; v.y = 10'd0;
            end else begin
                v.x = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(640, 1023))
                                                 : 10'($urandom_range(0, 639));
                v.y = 10'($urandom_range(0, 1023));
            end
            v.mode  = 2'($urandom_range(0, 3));
            v.bg    = 24'($urandom);
            v.data  = 24'($urandom);
            v.empty = ($urandom_range(0, 3) == 0);
            v.clr   = ($urandom_range(0, 19) == 0);
            model(v, o);
            apply(o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_out_stage.md
# pixel_out_stage

Parametrised, registered pixel output stage between the line-buffer FIFO and the VGA DAC/encoder. Each active pixel is drawn from one of four sources: FIFO pass-through, a solid background, colour bars or a checkerboard. It pops the first-word-fall-through FIFO itself and blanks outside the active area. It also detects, counts and flags FIFO underflow, and applies mode changes only at frame start.

## Interface
Parameters:
- COLOR_W, 8, bits per colour channel
- X_W, 10, pixel_x width
- Y_W, 10, pixel_y width
- H_ACTIVE, 640, active pixels per line (colour-bar width = H_ACTIVE/8, integer)
- CHECK_SHIFT, 5, checker square = 2^CHECK_SHIFT pixels
- CNT_W, 16, underflow counter width

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-low
- pixel_x  in  X_W  current column from timing generator
- pixel_y  in  Y_W  current row
- video_on  in  1  high in active display area
- mode  in  2  requested source: 0 FIFO, 1 solid, 2 bars, 3 checker
- bg_color  in  3*COLOR_W  {r,g,b} solid/underflow colour
- fifo_data  in  3*COLOR_W  {r,g,b} FWFT head word
- fifo_empty  in  1  FIFO empty
- fifo_rd_en  out  1  pop strobe (combinational)
- clr_underflow  in  1  clear flag and counter
- pixel_r/g/b  out  COLOR_W each  registered colour
- pixel_valid  out  1  registered copy of video_on
- frame_start  out  1  registered pulse, first active pixel of frame
- underflow  out  1  sticky underflow flag
- underflow_count  out  CNT_W  saturating underflow count

## Operation
- fs_cond = video_on && pixel_x==0 && pixel_y==0.
- active_mode register, reset 0. eff_mode = fs_cond ? mode : active_mode. On fs_cond, active_mode <= mode. Mid-frame changes to mode are ignored until the next fs_cond.
- fifo_rd_en = rst && video_on && eff_mode==0 && !fifo_empty. No pop during blanking or in non-FIFO modes.
- Colour select (next-state of pixel_r/g/b):
  - video_on low: 0.
  - eff_mode 0, FIFO not empty: fifo_data.
  - eff_mode 0, FIFO empty: bg_color, and an underflow event.
  - eff_mode 1: bg_color.
  - eff_mode 2: bar index k = largest k with pixel_x >= k*(H_ACTIVE/8), clamped to 7.
    - Bars 0..7 are white, yellow, cyan, green, magenta, red, blue, black.
    - Each channel is all-ones or 0.
  - eff_mode 3: pixel_x[CHECK_SHIFT]^pixel_y[CHECK_SHIFT]; 1 gives all-ones (white), 0 gives black.
- Underflow event: underflow <= 1. underflow_count increments and saturates at 2^CNT_W-1.
- clr_underflow alone: flag and count <= 0.
- clr_underflow together with an event: flag <= 1, count <= 1. The clear applies first, then the event.

## Timing
- Latency from pixel_x/pixel_y/video_on to pixel_r/g/b, pixel_valid and frame_start: 1 clk.
- fifo_rd_en is asserted in the same cycle the word is consumed. The consumed fifo_data appears on the outputs the next cycle.
- Reset state (rst low at a clk edge):
  - pixel_r/g/b = 0, pixel_valid = 0, frame_start = 0.
  - underflow = 0, underflow_count = 0, active_mode = 0.
  - fifo_rd_en = 0 combinationally while rst is low.
- Reset mid-frame: outputs are 0 the cycle after. Operation resumes in the FIFO source with no pops until video_on.
- Underflow is evaluated every active cycle in FIFO mode. N consecutive empty cycles produce N counts.

## Structure
- Package pixel_out_pkg holds:
  - MODE_FIFO/MODE_SOLID/MODE_BARS/MODE_CHECK constants.
  - A bar-colour function (index, COLOR_W) returning {r,g,b}.
- Sub-module pattern_gen (combinational): inputs pixel_x, pixel_y, eff_mode; output is the bars/checker colour.
- Top level holds mode latch, select mux, output registers and underflow logic.

## Test plan
- Reset: rst=0 for 3 clk with video_on=1, fifo non-empty → all outputs 0, fifo_rd_en=0. Release → first active pixel's fifo_data appears 1 clk later.
- FIFO pass-through: x=0..3, data 0x112233, 0x445566, ... → fifo_rd_en high 4 clk. Outputs match data with 1 clk lag. video_on=0 → rgb 0, no pop.
- Underflow: fifo_empty high for 5 active cycles, bg_color=0x0000FF → blue output, underflow=1, count=5.
  - clr_underflow alone → flag 0, count 0.
  - clr_underflow coincident with an event → count=1.
  - Force count to 2^CNT_W-1 and trigger one more event → count holds.
- Mode latch: set mode=2 mid-frame → output stays FIFO until fs_cond. At x=0,y=0 → white bar, frame_start pulses 1 clk later. x=80 → yellow, x=639 → black.
- Checker: mode=3 at frame start. (x,y)=(0,0) black, (32,0) white, (32,32) black.
